vend_payout_ctrl: RTL and testbench

//  Payout responder for the vending seller FSM. Accepts its dispense/half_out/collect

---
 rtl/vend_payout_ctrl.sv | 172 +++++++++++++++++
 tb/tb_vend_payout_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vend_payout_ctrl.sv
// Payout responder for the vending seller FSM: latches item / change / vault requests and
// drives timed solenoid pulses, confirming item and coin drops through the drop sensors.
module vend_payout_ctrl #(
    parameter int PULSE_CYC   = 5_000_000,
    parameter int TIMEOUT_CYC = 25_000_000,
    parameter int CNT_W       = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dispense,
    input  logic       half_out,
    input  logic       collect,
    input  logic       item_sense,
    input  logic       coin_sense,
    input  logic       fault_clr,
    output logic       item_sol,
    output logic       coin_sol,
    output logic       cash_gate,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic       overrun
);

    typedef enum logic [2:0] {
        IDLE, ITEM_ON, ITEM_WAIT, COIN_ON, COIN_WAIT, GATE_ON, FAULT
    } state_t;

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] timer, timer_next;
    logic             seen, seen_next;
    logic             pend_item, pend_coin, pend_gate;
    logic             pend_item_next, pend_coin_next, pend_gate_next;
    logic             dispense_prev, half_out_prev, collect_prev;
    logic             item_req, coin_req, gate_req;
    logic [1:0]       item_sync, coin_sync;
    logic             item_last, coin_last;
    logic             item_drop, coin_drop;
    logic             clr_item, clr_coin, clr_gate, clr_all;
    logic [1:0]       fault_code_next;
    logic             done_next, overrun_set;

    assign item_req  = dispense & ~dispense_prev;
    assign coin_req  = half_out & ~half_out_prev;
    assign gate_req  = collect & ~collect_prev;

    // Sensors idle high; a drop is the synchronized high-to-low transition.
    assign item_drop = item_last & ~item_sync[1];
    assign coin_drop = coin_last & ~coin_sync[1];

    assign fault = (state == FAULT);
    assign busy  = (state != IDLE) | pend_item | pend_coin | pend_gate;

    always_comb begin
        state_next      = state;
        timer_next      = timer;
        seen_next       = seen;
        clr_item        = 1'b0;
        clr_coin        = 1'b0;
        clr_gate        = 1'b0;
        clr_all         = 1'b0;
        fault_code_next = fault_code;
        case (state)
            IDLE: begin
                timer_next = '0;
                seen_next  = 1'b0;
                if (pend_item)      state_next = ITEM_ON;
                else if (pend_coin) state_next = COIN_ON;
                else if (pend_gate) state_next = GATE_ON;
            end
            ITEM_ON, COIN_ON: begin
                if ((state == ITEM_ON) ? item_drop : coin_drop) seen_next = 1'b1;
                if (timer == PULSE_LAST) begin
                    timer_next = '0;
                    state_next = (state == ITEM_ON) ? ITEM_WAIT : COIN_WAIT;
                end else begin
                    timer_next = timer + CNT_W'(1);
                end
            end
            ITEM_WAIT, COIN_WAIT: begin
                if (seen || ((state == ITEM_WAIT) ? item_drop : coin_drop)) begin
                    clr_item   = (state == ITEM_WAIT);
                    clr_coin   = (state == COIN_WAIT);
                    timer_next = '0;
                    state_next = IDLE;
                end else if (timer == TIMEOUT_LAST) begin
                    fault_code_next = (state == ITEM_WAIT) ? 2'b01 : 2'b10;
                    timer_next      = '0;
                    state_next      = FAULT;
                end else begin
                    timer_next = timer + CNT_W'(1);
                end
            end
            GATE_ON: begin
                if (timer == PULSE_LAST) begin
                    clr_gate   = 1'b1;
                    timer_next = '0;
                    state_next = IDLE;
                end else begin
                    timer_next = timer + CNT_W'(1);
                end
            end
            FAULT: begin
                timer_next = '0;
                if (fault_clr) begin
                    clr_all         = 1'b1;
                    fault_code_next = 2'b00;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // An edge on an already-pending request is flagged, never queued twice.
        pend_item_next = clr_all ? item_req : (pend_item ? ~clr_item : item_req);
        pend_coin_next = clr_all ? coin_req : (pend_coin ? ~clr_coin : coin_req);
        pend_gate_next = clr_all ? gate_req : (pend_gate ? ~clr_gate : gate_req);
        overrun_set    = (item_req & pend_item) | (coin_req & pend_coin) | (gate_req & pend_gate);
        done_next      = (clr_item | clr_coin | clr_gate)
                       & ~(pend_item_next | pend_coin_next | pend_gate_next);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            timer         <= '0;
            seen          <= 1'b0;
            pend_item     <= 1'b0;
            pend_coin     <= 1'b0;
            pend_gate     <= 1'b0;
            dispense_prev <= 1'b0;
            half_out_prev <= 1'b0;
            collect_prev  <= 1'b0;
            item_sync     <= 2'b11;
            coin_sync     <= 2'b11;
            item_last     <= 1'b1;
            coin_last     <= 1'b1;
            item_sol      <= 1'b0;
            coin_sol      <= 1'b0;
            cash_gate     <= 1'b0;
            done          <= 1'b0;
            fault_code    <= 2'b00;
            overrun       <= 1'b0;
        end else begin
            state         <= state_next;
            timer         <= timer_next;
            seen          <= seen_next;
            pend_item     <= pend_item_next;
            pend_coin     <= pend_coin_next;
            pend_gate     <= pend_gate_next;
            dispense_prev <= dispense;
            half_out_prev <= half_out;
            collect_prev  <= collect;
            item_sync     <= {item_sync[0], item_sense};
            coin_sync     <= {coin_sync[0], coin_sense};
            item_last     <= item_sync[1];
            coin_last     <= coin_sync[1];
            // Drives are registered from the next state so they are glitch-free.
            item_sol      <= (state_next == ITEM_ON);
            coin_sol      <= (state_next == COIN_ON);
            cash_gate     <= (state_next == GATE_ON);
            done          <= done_next;
            fault_code    <= fault_code_next;
            overrun       <= overrun | overrun_set;
        end
    end

endmodule

// File: tb/tb_vend_payout_ctrl.sv
// Bench for vend_payout_ctrl: directed scenarios plus randomized request mixes and sensor
// timings, checked against a transaction-level expectation of pulse order, width and faults.
module tb_vend_payout_ctrl;

    localparam int PULSE   = 4;
    localparam int TIMEOUT = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       dispense = 1'b0, half_out = 1'b0, collect = 1'b0;
    logic       item_sense = 1'b1, coin_sense = 1'b1;
    logic       fault_clr = 1'b0;
    logic       item_sol, coin_sol, cash_gate, busy, done, fault, overrun;
    logic [1:0] fault_code;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    vend_payout_ctrl #(.PULSE_CYC(PULSE), .TIMEOUT_CYC(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .dispense(dispense), .half_out(half_out),
        .collect(collect), .item_sense(item_sense), .coin_sense(coin_sense),
        .fault_clr(fault_clr), .item_sol(item_sol), .coin_sol(coin_sol),
        .cash_gate(cash_gate), .busy(busy), .done(done), .fault(fault),
        .fault_code(fault_code), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Actuator monitor: records every pulse as (kind, start cycle, width).
    int ev_kind[$], ev_start[$], ev_len[$];
    int done_cnt = 0, overlap_cnt = 0, fault_rise = 0;
    int s_act[3];
    logic [2:0] p_act = 3'b000;
    logic p_fault = 1'b0;

    always @(negedge clk) begin
        logic [2:0] a;
        a = {cash_gate, coin_sol, item_sol};
        for (int k = 0; k < 3; k++) begin
            if (a[k] && !p_act[k]) s_act[k] = cyc;
            if (!a[k] && p_act[k]) begin
                ev_kind.push_back(k);
                ev_start.push_back(s_act[k]);
                ev_len.push_back(cyc - s_act[k]);
            end
        end
        if ((int'(a[0]) + int'(a[1]) + int'(a[2])) > 1) overlap_cnt++;
        if (done) done_cnt++;
        if (fault && !p_fault) fault_rise = cyc;
        p_act   = a;
        p_fault = fault;
    end

    // Drop-sensor responder: t is the cycle offset from solenoid rise at which the sensor falls.
    int  item_t = 0, coin_t = 0;
    bit  item_resp = 1'b1, coin_resp = 1'b1;
    int  item_ph = -1, coin_ph = -1;
    logic p_isol = 1'b0, p_csol = 1'b0;

    always @(negedge clk) begin
        if (item_sol && !p_isol) item_ph = 0;
        else if (item_ph >= 0) item_ph = (item_ph >= 40) ? -1 : item_ph + 1;
        if (coin_sol && !p_csol) coin_ph = 0;
        else if (coin_ph >= 0) coin_ph = (coin_ph >= 40) ? -1 : coin_ph + 1;
        if (item_ph == item_t && item_resp) item_sense = 1'b0;
        if (item_ph == item_t + 2)          item_sense = 1'b1;
        if (coin_ph == coin_t && coin_resp) coin_sense = 1'b0;
        if (coin_ph == coin_t + 2)          coin_sense = 1'b1;
        p_isol = item_sol;
        p_csol = coin_sol;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        ev_kind.delete();
        ev_start.delete();
        ev_len.delete();
        done_cnt    = 0;
        overlap_cnt = 0;
    endtask

    // Issue the requests in mask (bit0 item, bit1 coin, bit2 gate) and compare the outcome
    // against the service order: item, coin, gate; a missing drop faults and stops service.
    task automatic run_scn(input string tag, input int mask, input int it, input int ct,
                           input bit ir, input bit cr);
        int  req_cyc, n, exp_code, exp_kind[$];
        bit  faulted, settled;
        clear_mon();
        item_t = it; coin_t = ct; item_resp = ir; coin_resp = cr;
        dispense = mask[0]; half_out = mask[1]; collect = mask[2];
        req_cyc = cyc;
        step();
        dispense = 1'b0; half_out = 1'b0; collect = 1'b0;
        check({tag, "_busy_on"}, busy, 1);
        settled = 1'b0;
        n = 0;
        while (n < 200) begin
            step();
            if (!busy || fault) begin
                settled = 1'b1;
                break;
            end
            n++;
        end
        check({tag, "_settle"}, settled, 1);
        step(3);

        faulted = 1'b0;
        exp_code = 0;
        if (mask[0]) begin
            exp_kind.push_back(0);
            if (!ir) begin faulted = 1'b1; exp_code = 1; end
        end
        if (!faulted && mask[1]) begin
            exp_kind.push_back(1);
            if (!cr) begin faulted = 1'b1; exp_code = 2; end
        end
        if (!faulted && mask[2]) exp_kind.push_back(2);

        check({tag, "_npulses"}, ev_kind.size(), exp_kind.size());
        for (int k = 0; k < exp_kind.size() && k < ev_kind.size(); k++) begin
            check({tag, "_kind"}, ev_kind[k], exp_kind[k]);
            check({tag, "_width"}, ev_len[k], PULSE);
        end
        if (ev_start.size() > 0) check({tag, "_latency"}, ev_start[0] - req_cyc, 2);
        check({tag, "_overlap"}, overlap_cnt, 0);
        check({tag, "_done_cnt"}, done_cnt, faulted ? 0 : 1);
        check({tag, "_fault"}, fault, faulted);
        check({tag, "_fault_code"}, fault_code, exp_code);
        check({tag, "_drives_off"}, {item_sol, coin_sol, cash_gate}, 0);
        if (faulted) begin
            if (ev_start.size() > 0)
                check({tag, "_fault_time"}, fault_rise - ev_start[ev_start.size()-1],
                      PULSE + TIMEOUT);
            check({tag, "_busy_fault"}, busy, 1);
            fault_clr = 1'b1;
            step();
            fault_clr = 1'b0;
            check({tag, "_clr_fault"}, fault, 0);
            check({tag, "_clr_code"}, fault_code, 0);
            check({tag, "_clr_busy"}, busy, 0);
        end else begin
            check({tag, "_busy_off"}, busy, 0);
        end
        check({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        step(3);
        check("rst_drives", {item_sol, coin_sol, cash_gate}, 0);
        check("rst_status", {busy, done, fault, overrun}, 0);
        check("rst_code", fault_code, 0);
        reset = 1'b1;
        step(2);
        check("idle_busy", busy, 0);

        // Item with drop 3 cycles after release; all three at once; coin timeout; early drop.
        run_scn("item", 1, PULSE + 3, 0, 1'b1, 1'b1);
        run_scn("all3", 7, $urandom_range(11, 0), $urandom_range(11, 0), 1'b1, 1'b1);
        run_scn("coin_to", 2, 0, 0, 1'b1, 1'b0);
        run_scn("early", 1, 1, 0, 1'b1, 1'b1);

        for (int i = 0; i < 16; i++) begin
            run_scn("rnd", $urandom_range(7, 1), $urandom_range(11, 0), $urandom_range(11, 0),
                    $urandom_range(4, 0) != 0, $urandom_range(4, 0) != 0);
        end

        // Second dispense edge while the first is still pending.
        clear_mon();
        item_t = 5; item_resp = 1'b1;
        dispense = 1'b1; step();
        dispense = 1'b0; step();
        dispense = 1'b1; step();
        dispense = 1'b0;
        step(30);
        check("ovr_flag", overrun, 1);
        check("ovr_npulses", ev_kind.size(), 1);
        check("ovr_done", done_cnt, 1);
        check("ovr_busy", busy, 0);

        // Reset asserted in the second ITEM_ON cycle.
        clear_mon();
        item_resp = 1'b0;
        dispense = 1'b1; step();
        dispense = 1'b0; step();
        check("rst_mid_on", item_sol, 1);
        step();
        reset = 1'b0;
        step();
        check("rst_mid_sol", item_sol, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ovr", overrun, 0);
        reset = 1'b1;
        step(20);
        check("rst_mid_npulses", ev_kind.size(), 1);
        if (ev_len.size() > 0) check("rst_mid_width", ev_len[0], 2);
        check("rst_mid_idle", {busy, fault, done_cnt != 0}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
